ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/keyboard_pkg.sv | 27 ++
 rtl/ps2_key_decoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/keyboard_pkg.sv
// keyboard_pkg: PS/2 set-2 scan codes and decoder state encoding shared by the keyboard logic.
// Revision 1.0
`default_nettype none

package keyboard_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_BREAK     = 2'd1;
   localparam state_t ST_EXT       = 2'd2;
   localparam state_t ST_EXT_BREAK = 2'd3;

   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ERR0  = 8'h00;
   localparam logic [7:0] SC_ERR1  = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns a stream of PS/2 set-2 scan bytes into held-key levels for a few game keys.
// Revision 1.0
`default_nettype none

module ps2_key_decoder
   import keyboard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 130000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       key_space,
   output logic       key_left,
   output logic       key_right,
   output logic       key_esc,
   output logic       space_press
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             space_key;
   logic             a_key;
   logic             d_key;
   logic             arrow_left;
   logic             arrow_right;
   logic             esc_key;
   logic             press;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         space_key   <= 1'b0;
         a_key       <= 1'b0;
         d_key       <= 1'b0;
         arrow_left  <= 1'b0;
         arrow_right <= 1'b0;
         esc_key     <= 1'b0;
         press       <= 1'b0;
      end else begin
         press <= 1'b0;
         if (rx_valid) begin
            cnt <= '0;
            // A line-error byte means our view of which keys are down is untrustworthy.
            if (rx_data == SC_ERR0 || rx_data == SC_ERR1) begin
               state       <= ST_IDLE;
               space_key   <= 1'b0;
               a_key       <= 1'b0;
               d_key       <= 1'b0;
               arrow_left  <= 1'b0;
               arrow_right <= 1'b0;
               esc_key     <= 1'b0;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (rx_data == SC_BREAK) begin
                        state <= ST_BREAK;
                     end else if (rx_data == SC_EXT) begin
                        state <= ST_EXT;
                     end else begin
                        state <= ST_IDLE;
                        case (rx_data)
                           SC_SPACE: begin
                              space_key <= 1'b1;
                              press     <= ~space_key;
                           end
                           SC_A:    a_key   <= 1'b1;
                           SC_D:    d_key   <= 1'b1;
                           SC_ESC:  esc_key <= 1'b1;
                           default: ;
                        endcase
                     end
                  end
                  ST_BREAK: begin
                     if (rx_data != SC_BREAK) begin
                        state <= ST_IDLE;
                        case (rx_data)
                           SC_SPACE: space_key <= 1'b0;
                           SC_A:     a_key     <= 1'b0;
                           SC_D:     d_key     <= 1'b0;
                           SC_ESC:   esc_key   <= 1'b0;
                           default:  ;
                        endcase
                     end
                  end
                  ST_EXT: begin
                     if (rx_data == SC_BREAK) begin
                        state <= ST_EXT_BREAK;
                     end else if (rx_data != SC_EXT) begin
                        state <= ST_IDLE;
                        if (rx_data == SC_LEFT)  arrow_left  <= 1'b1;
                        if (rx_data == SC_RIGHT) arrow_right <= 1'b1;
                     end
                  end
                  default: begin
                     state <= ST_IDLE;
                     if (rx_data == SC_LEFT)  arrow_left  <= 1'b0;
                     if (rx_data == SC_RIGHT) arrow_right <= 1'b0;
                  end
               endcase
            end
         end else if (state == ST_IDLE) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            // Abandon a stale prefix; held keys keep their last known level.
            state <= ST_IDLE;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign key_space   = space_key;
   assign key_left    = arrow_left | a_key;
   assign key_right   = arrow_right | d_key;
   assign key_esc     = esc_key;
   assign space_press = press;

endmodule

`default_nettype wire
